// File: rtl/viterbi_channel_inj.sv
//------------------------------------------------------------------------------
// viterbi_channel_inj
//
// Purpose:
//   Channel error injector placed between a rate-1/2 convolutional encoder
//   and a Viterbi decoder. It passes code symbols through with one cycle of
//   latency. It can flip exactly one bit of a symbol, either periodically or
//   pseudo-randomly under a 16-bit LFSR. Two injections are always separated
//   by at least MIN_GAP clean valid symbols.
//
// Parameters:
//   MIN_GAP  minimum clean valid symbols between injections (2..255)
//   SEED     nonzero LFSR load value at reset
//   CNT_W    width of error_counter
//
// Ports:
//   clk            in   single rising-edge clock
//   rst            in   synchronous active-high reset
//   sym_i[1:0]     in   encoder symbol, bit1 = G0 output, bit0 = G1 output
//   sym_valid_i    in   sym_i is valid this cycle
//   err_en         in   error injection enable
//   mode[1:0]      in   00 pass, 01 periodic, 10 random, 11 pass
//   sym_o[1:0]     out  channel symbol (registered, possibly corrupted)
//   sym_valid_o    out  sym_o is valid
//   err_inj        out  sym_o carries an injected error
//   error_counter  out  saturating count of injected bit errors
//------------------------------------------------------------------------------
module viterbi_channel_inj #(
    parameter int          MIN_GAP = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sym_i,
    input  logic             sym_valid_i,
    input  logic             err_en,
    input  logic [1:0]       mode,
    output logic [1:0]       sym_o,
    output logic             sym_valid_o,
    output logic             err_inj,
    output logic [CNT_W-1:0] error_counter
);

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        COOLDOWN = 2'd1,
        ARMED    = 2'd2
    } state_t;

    localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);

    state_t           r_state;
    logic [15:0]      r_lfsr;
    logic [7:0]       r_gap;
    logic             r_toggle;
    logic [1:0]       r_sym;
    logic             r_valid;
    logic             r_inj;
    logic [CNT_W-1:0] r_cnt;

    logic             w_injEn;
    logic             w_periodic;
    logic [7:0]       w_gapInc;
    logic             w_trigger;
    logic             w_inject;
    logic             w_bitSel;
    logic [1:0]       w_flipMask;
    logic             w_lfsrFb;

    // Injection is only possible in periodic or random mode with err_en set.
    // The trigger condition is read from the mode of the current symbol.
    // So a mode change acts on the very next valid symbol.
    always_comb begin
        w_injEn    = err_en && ((mode == 2'b01) || (mode == 2'b10));
        w_periodic = (mode == 2'b01);
        w_gapInc   = (r_gap == GAP_MAX) ? r_gap : (r_gap + 8'd1);
        w_trigger  = w_periodic || (r_lfsr[3:0] == 4'b0000);
        w_inject   = sym_valid_i && w_injEn && (r_state == ARMED) && w_trigger;
        w_bitSel   = w_periodic ? r_toggle : r_lfsr[4];
        w_flipMask = w_bitSel ? 2'b10 : 2'b01;
        // Taps 16,14,13,11 of a right-shifting Fibonacci register.
        w_lfsrFb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    end

    // The output stage, the LFSR, the gap counter, the toggle, the error
    // counter and the FSM all sit in one block. Everything except the
    // output stage advances only on valid symbols. ARMED always implies that
    // the gap counter sits at MIN_GAP. Transitions into ARMED look at the
    // post-increment gap value. Because of this, a stream that saturated the
    // gap while in PASS arms at once rather than stalling in COOLDOWN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym    <= 2'b00;
            r_valid  <= 1'b0;
            r_inj    <= 1'b0;
            r_cnt    <= '0;
            r_lfsr   <= SEED;
            r_gap    <= 8'd0;
            r_toggle <= 1'b0;
            r_state  <= w_injEn ? COOLDOWN : PASS;
        end else begin
            r_sym   <= w_inject ? (sym_i ^ w_flipMask) : sym_i;
            r_valid <= sym_valid_i;
            r_inj   <= w_inject;
            if (sym_valid_i) begin
                r_lfsr <= {w_lfsrFb, r_lfsr[15:1]};
                r_gap  <= w_inject ? 8'd0 : w_gapInc;
                if (w_inject) begin
                    r_toggle <= ~r_toggle;
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (!w_injEn) begin
                    r_state <= PASS;
                end else begin
                    case (r_state)
                        PASS:     r_state <= (w_gapInc == GAP_MAX) ? ARMED : COOLDOWN;
                        COOLDOWN: r_state <= (w_gapInc == GAP_MAX) ? ARMED : COOLDOWN;
                        ARMED:    r_state <= w_inject ? COOLDOWN : ARMED;
                        default:  r_state <= COOLDOWN;
                    endcase
                end
            end
        end
    end

    assign sym_o         = r_sym;
    assign sym_valid_o   = r_valid;
    assign err_inj       = r_inj;
    assign error_counter = r_cnt;

endmodule

// File: tb/tb_viterbi_channel_inj.sv
//------------------------------------------------------------------------------
// tb_viterbi_channel_inj
//
// Directed bench for viterbi_channel_inj. The main instance uses the default
// parameters. A second instance with MIN_GAP=2 and CNT_W=4 exercises counter
// saturation.
//------------------------------------------------------------------------------
module tb_viterbi_channel_inj;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sym_i;
    logic        sym_valid_i;
    logic        err_en;
    logic [1:0]  mode;
    logic [1:0]  sym_o;
    logic        sym_valid_o;
    logic        err_inj;
    logic [15:0] error_counter;

    logic        rst2;
    logic [1:0]  sym2;
    logic        valid2;
    logic [1:0]  sym2_o;
    logic        valid2_o;
    logic        inj2_o;
    logic [3:0]  cnt2_o;

    int testsRun    = 0;
    int testsFailed = 0;

    viterbi_channel_inj dut (
        .clk           (clk),
        .rst           (rst),
        .sym_i         (sym_i),
        .sym_valid_i   (sym_valid_i),
        .err_en        (err_en),
        .mode          (mode),
        .sym_o         (sym_o),
        .sym_valid_o   (sym_valid_o),
        .err_inj       (err_inj),
        .error_counter (error_counter)
    );

    viterbi_channel_inj #(.MIN_GAP(2), .SEED(16'hACE1), .CNT_W(4)) dutSat (
        .clk           (clk),
        .rst           (rst2),
        .sym_i         (sym2),
        .sym_valid_i   (valid2),
        .err_en        (1'b1),
        .mode          (2'b01),
        .sym_o         (sym2_o),
        .sym_valid_o   (valid2_o),
        .err_inj       (inj2_o),
        .error_counter (cnt2_o)
    );

    always #5 clk = ~clk;

    // Presents one input cycle, then waits until just after the capturing edge
    // so the registered outputs belong to this symbol.
    task automatic applyStimulus(input logic [1:0] s, input logic v);
        sym_i       = s;
        sym_valid_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reset with a valid symbol present, which must be dropped.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b11, 1'b1);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] refLfsr(input logic [15:0] v);
        logic fb;
        fb = v[16-16] ^ v[16-14] ^ v[16-13] ^ v[16-11];
        return {fb, v[15:1]};
    endfunction

    initial begin
        logic [1:0]  expSym;
        logic        expErr;
        int          errNo;
        int          k;
        logic [15:0] mLfsr;
        int          mGap;
        int          mCount;
        int          lastInj;
        logic [1:0]  rs;
        logic [3:0]  prevCnt;
        logic        wrapped;

        rst         = 1'b0;
        sym_i       = 2'b00;
        sym_valid_i = 1'b0;
        err_en      = 1'b1;
        mode        = 2'b01;
        rst2        = 1'b1;
        sym2        = 2'b00;
        valid2      = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        doReset();
        checkOutput("reset_sym_o", 32'(sym_o), 32'h0);
        checkOutput("reset_valid_o", 32'(sym_valid_o), 32'h0);
        checkOutput("reset_err_inj", 32'(err_inj), 32'h0);
        checkOutput("reset_counter", 32'(error_counter), 32'h0);

        // Pass-through, mode 00
        mode = 2'b00;
        doReset();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(2'b10, 1'b1);
            checkOutput("pass_sym", 32'(sym_o), 32'h2);
            checkOutput("pass_valid", 32'(sym_valid_o), 32'h1);
            checkOutput("pass_inj", 32'(err_inj), 32'h0);
        end
        checkOutput("pass_counter", 32'(error_counter), 32'h0);

        // Periodic, continuous valid
        mode = 2'b01;
        doReset();
        errNo = 0;
        for (int i = 0; i < 100; i++) begin
            expErr = (i == 16) || (i == 33) || (i == 50) || (i == 67) || (i == 84);
            expSym = expErr ? (((errNo % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            if (expErr) errNo++;
            applyStimulus(2'b00, 1'b1);
            checkOutput("per_sym", 32'(sym_o), 32'(expSym));
            checkOutput("per_inj", 32'(err_inj), 32'(expErr));
        end
        checkOutput("per_counter", 32'(error_counter), 32'd5);

        // Periodic with valid deasserted every other cycle
        doReset();
        errNo = 0;
        for (int c = 0; c < 200; c++) begin
            if ((c % 2) == 0) begin
                k      = c / 2;
                expErr = (k == 16) || (k == 33) || (k == 50) || (k == 67) || (k == 84);
                expSym = expErr ? (((errNo % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
                if (expErr) errNo++;
                applyStimulus(2'b00, 1'b1);
                checkOutput("gap_valid_hi", 32'(sym_valid_o), 32'h1);
                checkOutput("gap_sym", 32'(sym_o), 32'(expSym));
                checkOutput("gap_inj", 32'(err_inj), 32'(expErr));
            end else begin
                applyStimulus(2'b11, 1'b0);
                checkOutput("gap_valid_lo", 32'(sym_valid_o), 32'h0);
                checkOutput("gap_inj_idle", 32'(err_inj), 32'h0);
            end
        end
        checkOutput("gap_counter", 32'(error_counter), 32'd5);

        // Reset mid-run after 40 symbols
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(2'b00, 1'b1);
        checkOutput("mid_counter_pre", 32'(error_counter), 32'd2);
        doReset();
        checkOutput("mid_sym_o", 32'(sym_o), 32'h0);
        checkOutput("mid_valid_o", 32'(sym_valid_o), 32'h0);
        checkOutput("mid_inj", 32'(err_inj), 32'h0);
        checkOutput("mid_counter", 32'(error_counter), 32'h0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2'b00, 1'b1);
            checkOutput("mid_post_sym", 32'(sym_o), (i == 16) ? 32'h1 : 32'h0);
            checkOutput("mid_post_inj", 32'(err_inj), (i == 16) ? 32'h1 : 32'h0);
        end

        // Random mode against a reference LFSR model
        mode = 2'b10;
        doReset();
        mLfsr   = 16'hACE1;
        mGap    = 0;
        mCount  = 0;
        lastInj = -1;
        for (int i = 0; i < 4096; i++) begin
            rs     = 2'($urandom_range(0, 3));
            expErr = (mGap == 16) && (mLfsr[3:0] == 4'b0000);
            expSym = expErr ? (rs ^ (mLfsr[4] ? 2'b10 : 2'b01)) : rs;
            if (expErr) begin
                mGap = 0;
                mCount++;
            end else if (mGap < 16) begin
                mGap++;
            end
            mLfsr = refLfsr(mLfsr);
            applyStimulus(rs, 1'b1);
            checkOutput("rnd_sym", 32'(sym_o), 32'(expSym));
            checkOutput("rnd_inj", 32'(err_inj), 32'(expErr));
            if (err_inj === 1'b1) begin
                checkOutput("rnd_spacing_ok", 32'((i - lastInj - 1) >= 16), 32'h1);
                lastInj = i;
            end
        end
        checkOutput("rnd_counter", 32'(error_counter), 32'(mCount));
        checkOutput("rnd_has_inj", 32'(mCount > 0), 32'h1);

        // Saturation on the narrow-counter instance
        sym_valid_i = 1'b0;
        rst2        = 1'b0;
        wrapped     = 1'b0;
        prevCnt     = 4'h0;
        for (int i = 0; i < 200; i++) begin
            sym2   = 2'b00;
            valid2 = 1'b1;
            @(posedge clk);
            #1;
            if (i == 2) checkOutput("sat_first", 32'(cnt2_o), 32'h1);
            if (cnt2_o < prevCnt) wrapped = 1'b1;
            prevCnt = cnt2_o;
        end
        checkOutput("sat_no_wrap", 32'(wrapped), 32'h0);
        checkOutput("sat_counter", 32'(cnt2_o), 32'hF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
